// File: rtl/jelly_param_update_pkg.sv
// Shared definitions for the parameter-update handshake blocks:
// FSM state encodings and a counter-width helper.
package jelly_param_update_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of a counter that must hold the values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jelly_param_update_master_if.sv
// Handshake bundle between the update master and its user/slave side.
// master: request/index in, update/status out; slave: the opposite view.
interface jelly_param_update_master_if #(
    parameter int INDEX_WIDTH = 1
);
    logic                   in_update_req;
    logic                   in_continuous;
    logic [INDEX_WIDTH-1:0] in_index;
    logic                   out_update;
    logic [INDEX_WIDTH-1:0] out_index;
    logic                   out_busy;
    logic                   out_ack;
    logic                   out_timeout;

    modport master (
        input  in_update_req,
        input  in_continuous,
        input  in_index,
        output out_update,
        output out_index,
        output out_busy,
        output out_ack,
        output out_timeout
    );

    modport slave (
        output in_update_req,
        output in_continuous,
        output in_index,
        input  out_update,
        input  out_index,
        input  out_busy,
        input  out_ack,
        input  out_timeout
    );

endinterface

// File: rtl/jelly_param_update_index_sync.sv
// Three-flop synchronizer for the slave bank index plus a stability filter.
// Ports: reset_n/clk, in_index (async), out_index (filtered, clk domain).
module jelly_param_update_index_sync #(
    parameter int INDEX_WIDTH = 1
) (
    input  logic                   reset_n,
    input  logic                   clk,
    input  logic [INDEX_WIDTH-1:0] in_index,
    output logic [INDEX_WIDTH-1:0] out_index
);

    (* ASYNC_REG = "TRUE" *) logic [INDEX_WIDTH-1:0] ff0_q;
    (* ASYNC_REG = "TRUE" *) logic [INDEX_WIDTH-1:0] ff1_q;
    logic [INDEX_WIDTH-1:0] ff2_q;
    logic [INDEX_WIDTH-1:0] sync_q;

    // A multi-bit index may be caught mid-transition; only accept a value
    // seen on two consecutive samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff0_q  <= '0;
            ff1_q  <= '0;
            ff2_q  <= '0;
            sync_q <= '0;
        end else begin
            ff0_q <= in_index;
            ff1_q <= ff0_q;
            ff2_q <= ff1_q;
            if (ff1_q == ff2_q) begin
                sync_q <= ff1_q;
            end
        end
    end

    assign out_index = sync_q;

endmodule

// File: rtl/jelly_param_update_master.sv
// Register-domain side of the async parameter-update handshake.
// Ports: reset_n, clk, cke, bus (master modport: req/continuous/index in,
// update/index/busy/ack/timeout out). Optional macro:
// JELLY_PARAM_UPDATE_MASTER_TIMEOUT_EN adds the REQ abort timer.
module jelly_param_update_master
    import jelly_param_update_pkg::*;
#(
    parameter int INDEX_WIDTH    = 1,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TIMEOUT_WIDTH  = 21
) (
    input  logic reset_n,
    input  logic clk,
    input  logic cke,
    jelly_param_update_master_if.master bus
);

    localparam int HW = cnt_width(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   upd_q, upd_d;
    logic                   ack_q, ack_d;
    logic                   to_q, to_d;
    logic [INDEX_WIDTH-1:0] base_q, base_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [INDEX_WIDTH-1:0] sync_index;
    logic                   tclr;
    logic                   tinc;
    logic                   to_hit;

    jelly_param_update_index_sync #(
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_sync (
        .reset_n  (reset_n),
        .clk      (clk),
        .in_index (bus.in_index),
        .out_index(sync_index)
    );

`ifdef JELLY_PARAM_UPDATE_MASTER_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (tclr) begin
            tcnt_d = '0;
        end else if (tinc) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign to_hit = (tcnt_q == TO_LAST);
`else
    localparam int unused_to_cfg = TIMEOUT_CYCLES + TIMEOUT_WIDTH;
    logic unused_tctl;

    assign unused_tctl = tclr | tinc;
    assign to_hit      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        upd_d   = upd_q;
        base_d  = base_q;
        hcnt_d  = hcnt_q;
        ack_d   = 1'b0;
        to_d    = 1'b0;
        tclr    = 1'b0;
        tinc    = 1'b0;
        if (cke) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_update_req) begin
                        base_d  = sync_index;
                        upd_d   = 1'b1;
                        state_d = REQ;
                        tclr    = 1'b1;
                    end
                end
                REQ: begin
                    // index change beats timeout beats request drop
                    if (sync_index != base_q) begin
                        ack_d  = 1'b1;
                        base_d = sync_index;
                        if (bus.in_continuous && bus.in_update_req) begin
                            tclr = 1'b1;
                        end else begin
                            upd_d   = 1'b0;
                            state_d = HOLD;
                            hcnt_d  = '0;
                        end
                    end else if (to_hit) begin
                        to_d    = 1'b1;
                        upd_d   = 1'b0;
                        state_d = HOLD;
                        hcnt_d  = '0;
                    end else if (!bus.in_update_req) begin
                        upd_d   = 1'b0;
                        state_d = HOLD;
                        hcnt_d  = '0;
                    end else begin
                        tinc = 1'b1;
                    end
                end
                HOLD: begin
                    if (hcnt_q == HOLD_LAST) begin
                        state_d = IDLE;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    upd_d   = 1'b0;
                end
            endcase
        end
    end

    // ack/timeout are rebuilt every cycle, so they self-clear even when
    // cke is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            upd_q   <= 1'b0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
            base_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            upd_q   <= upd_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
            base_q  <= base_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign bus.out_update  = upd_q;
    assign bus.out_index   = sync_index;
    assign bus.out_busy    = (state_q != IDLE);
    assign bus.out_ack     = ack_q;
    assign bus.out_timeout = to_q;

endmodule

// File: tb/tb_jelly_param_update_master.sv
// Self-checking bench for jelly_param_update_master: one-shot, continuous,
// glitch filter, cke gating, timeout (macro-dependent) and mid-op reset.
module tb_jelly_param_update_master;

    localparam int IW   = 2;
    localparam int HOLD = 8;
    localparam int TOC  = 16;
    localparam int TOW  = 5;

    logic clk = 1'b0;
    logic reset_n;
    logic cke;

    jelly_param_update_master_if #(.INDEX_WIDTH(IW)) bus ();

    jelly_param_update_master #(
        .INDEX_WIDTH   (IW),
        .HOLDOFF_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TOC),
        .TIMEOUT_WIDTH (TOW)
    ) dut (
        .reset_n(reset_n),
        .clk    (clk),
        .cke    (cke),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_ack = 0;
    int n_to  = 0;

    // value the slave index has settled on (what out_index must show)
    logic [IW-1:0] model_idx;

    always @(negedge clk) begin
        if (bus.out_ack === 1'b1) n_ack++;
        if (bus.out_timeout === 1'b1) n_to++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // number of sampled cycles with busy high before it falls (bounded)
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.out_busy === 1'b1 && n < 200) begin
            n++;
            step(1);
        end
    endtask

    function automatic logic [IW-1:0] pick_new(input logic [IW-1:0] cur);
        return cur + IW'($urandom_range(1, (1 << IW) - 1));
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        cke = 1'b1;
        bus.in_update_req = 1'b0;
        bus.in_continuous = 1'b0;
        bus.in_index = '0;
        model_idx = '0;
        #23;
        total++;
        if (bus.out_update !== 1'b0) begin
            bad++; $display("FAIL reset_update got=%b exp=0", bus.out_update);
        end
        total++;
        if (bus.out_index !== '0) begin
            bad++; $display("FAIL reset_index got=%0d exp=0", bus.out_index);
        end
        total++;
        if (bus.out_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", bus.out_busy);
        end
        total++;
        if (bus.out_ack !== 1'b0 || bus.out_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses got ack=%b to=%b exp 0/0",
                     bus.out_ack, bus.out_timeout);
        end
        step(1);
        reset_n = 1'b1;
        step(3);
    endtask

    task automatic test_oneshot(input logic [IW-1:0] nv, input string tag);
        int a0;
        int n;
        a0 = n_ack;
        bus.in_continuous = 1'b0;
        bus.in_update_req = 1'b1;
        bus.in_index = nv;
        step(1);
        total++;
        if (bus.out_update !== 1'b1 || bus.out_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_start got upd=%b busy=%b exp 1/1",
                     tag, bus.out_update, bus.out_busy);
        end
        step(3);
        total++;
        if (bus.out_index !== nv || bus.out_ack !== 1'b0) begin
            bad++;
            $display("FAIL %s_sync got idx=%0d ack=%b exp %0d/0",
                     tag, bus.out_index, bus.out_ack, nv);
        end
        step(1);
        total++;
        if (bus.out_ack !== 1'b1 || bus.out_update !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack got ack=%b upd=%b exp 1/0",
                     tag, bus.out_ack, bus.out_update);
        end
        bus.in_update_req = 1'b0;
        model_idx = nv;
        wait_idle(n);
        total++;
        if (n !== HOLD) begin
            bad++; $display("FAIL %s_hold got=%0d exp=%0d", tag, n, HOLD);
        end
        total++;
        if (n_ack - a0 !== 1) begin
            bad++; $display("FAIL %s_nack got=%0d exp=1", tag, n_ack - a0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            test_oneshot(pick_new(model_idx), "b2b");
            step($urandom_range(0, 3));
        end
    endtask

    task automatic test_continuous();
        int a0;
        int nchg;
        int hold;
        int upd_err;
        int n;
        logic [IW-1:0] nv;
        a0 = n_ack;
        upd_err = 0;
        bus.in_continuous = 1'b1;
        bus.in_update_req = 1'b1;
        step(1);
        nchg = 3 + int'($urandom_range(0, 2));
        for (int i = 0; i < nchg; i++) begin
            nv = pick_new(model_idx);
            bus.in_index = nv;
            hold = int'($urandom_range(6, 12));
            for (int j = 0; j < hold; j++) begin
                step(1);
                if (bus.out_update !== 1'b1) upd_err++;
            end
            model_idx = nv;
            total++;
            if (bus.out_index !== nv) begin
                bad++;
                $display("FAIL cont_index[%0d] got=%0d exp=%0d",
                         i, bus.out_index, nv);
            end
        end
        total++;
        if (upd_err !== 0) begin
            bad++; $display("FAIL cont_update_drops got=%0d exp=0", upd_err);
        end
        total++;
        if (n_ack - a0 !== nchg) begin
            bad++;
            $display("FAIL cont_nack got=%0d exp=%0d", n_ack - a0, nchg);
        end
        bus.in_update_req = 1'b0;
        bus.in_continuous = 1'b0;
        wait_idle(n);
        total++;
        if (bus.out_busy !== 1'b0 || bus.out_update !== 1'b0) begin
            bad++;
            $display("FAIL cont_end got busy=%b upd=%b exp 0/0",
                     bus.out_busy, bus.out_update);
        end
    endtask

    task automatic test_glitch();
        int a0;
        int n;
        a0 = n_ack;
        bus.in_update_req = 1'b1;
        step(1);
        bus.in_index = pick_new(model_idx);
        step(1);
        bus.in_index = model_idx;
        step(6);
        total++;
        if (bus.out_index !== model_idx) begin
            bad++;
            $display("FAIL glitch_index got=%0d exp=%0d",
                     bus.out_index, model_idx);
        end
        total++;
        if (n_ack !== a0 || bus.out_update !== 1'b1) begin
            bad++;
            $display("FAIL glitch_ack got acks=%0d upd=%b exp 0/1",
                     n_ack - a0, bus.out_update);
        end
        bus.in_update_req = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_cke();
        int a0;
        int n;
        logic [IW-1:0] nv;
        a0 = n_ack;
        nv = pick_new(model_idx);
        bus.in_update_req = 1'b1;
        step(1);
        cke = 1'b0;
        bus.in_index = nv;
        step(10);
        total++;
        if (bus.out_index !== nv) begin
            bad++;
            $display("FAIL cke_sync got=%0d exp=%0d", bus.out_index, nv);
        end
        total++;
        if (n_ack !== a0 || bus.out_update !== 1'b1 || bus.out_busy !== 1'b1) begin
            bad++;
            $display("FAIL cke_frozen got acks=%0d upd=%b busy=%b exp 0/1/1",
                     n_ack - a0, bus.out_update, bus.out_busy);
        end
        cke = 1'b1;
        step(1);
        total++;
        if (bus.out_ack !== 1'b1 || bus.out_update !== 1'b0) begin
            bad++;
            $display("FAIL cke_ack got ack=%b upd=%b exp 1/0",
                     bus.out_ack, bus.out_update);
        end
        cke = 1'b0;
        bus.in_update_req = 1'b0;
        step(1);
        total++;
        if (bus.out_ack !== 1'b0 || bus.out_busy !== 1'b1) begin
            bad++;
            $display("FAIL cke_ack_clear got ack=%b busy=%b exp 0/1",
                     bus.out_ack, bus.out_busy);
        end
        step(3);
        cke = 1'b1;
        model_idx = nv;
        wait_idle(n);
        total++;
        if (bus.out_busy !== 1'b0 || n_ack - a0 !== 1) begin
            bad++;
            $display("FAIL cke_end got busy=%b acks=%0d exp 0/1",
                     bus.out_busy, n_ack - a0);
        end
    endtask

    task automatic test_timeout();
        int a0;
        int t0;
        int n;
        a0 = n_ack;
        t0 = n_to;
        bus.in_continuous = 1'b0;
        bus.in_update_req = 1'b1;
        step(1);
`ifdef JELLY_PARAM_UPDATE_MASTER_TIMEOUT_EN
        step(TOC - 1);
        total++;
        if (bus.out_timeout !== 1'b0 || bus.out_update !== 1'b1) begin
            bad++;
            $display("FAIL to_early got to=%b upd=%b exp 0/1",
                     bus.out_timeout, bus.out_update);
        end
        step(1);
        total++;
        if (bus.out_timeout !== 1'b1 || bus.out_update !== 1'b0 ||
            bus.out_ack !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse got to=%b upd=%b ack=%b exp 1/0/0",
                     bus.out_timeout, bus.out_update, bus.out_ack);
        end
        bus.in_update_req = 1'b0;
        wait_idle(n);
        total++;
        if (n !== HOLD || n_to - t0 !== 1 || n_ack !== a0) begin
            bad++;
            $display("FAIL to_end got hold=%0d to=%0d ack=%0d exp %0d/1/0",
                     n, n_to - t0, n_ack - a0, HOLD);
        end
`else
        step(3 * TOC);
        total++;
        if (bus.out_busy !== 1'b1 || bus.out_update !== 1'b1 ||
            n_to !== t0) begin
            bad++;
            $display("FAIL nto_wait got busy=%b upd=%b to=%0d exp 1/1/0",
                     bus.out_busy, bus.out_update, n_to - t0);
        end
        bus.in_update_req = 1'b0;
        wait_idle(n);
        total++;
        if (n_ack !== a0 || bus.out_busy !== 1'b0) begin
            bad++;
            $display("FAIL nto_end got acks=%0d busy=%b exp 0/0",
                     n_ack - a0, bus.out_busy);
        end
`endif
    endtask

    task automatic test_midop_reset();
        int a0;
        logic [IW-1:0] nv;
        a0 = n_ack;
        nv = pick_new(model_idx);
        bus.in_update_req = 1'b1;
        step(1);
        bus.in_index = nv;
        step(2);
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.out_update !== 1'b0 || bus.out_busy !== 1'b0 ||
            bus.out_index !== '0) begin
            bad++;
            $display("FAIL rst_mid got upd=%b busy=%b idx=%0d exp 0/0/0",
                     bus.out_update, bus.out_busy, bus.out_index);
        end
        step(2);
        bus.in_update_req = 1'b0;
        reset_n = 1'b1;
        step(5);
        model_idx = nv;
        total++;
        if (bus.out_index !== nv || bus.out_busy !== 1'b0 || n_ack !== a0) begin
            bad++;
            $display("FAIL rst_after got idx=%0d busy=%b acks=%0d exp %0d/0/0",
                     bus.out_index, bus.out_busy, n_ack - a0, nv);
        end
        test_oneshot(pick_new(model_idx), "rst_new");
    endtask

    initial begin
        test_reset();
        test_oneshot(pick_new(model_idx), "oneshot");
        test_back_to_back();
        test_continuous();
        test_glitch();
        test_cke();
        test_timeout();
        test_midop_reset();
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
